elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_pkg.sv | 14 +
 rtl/cycle_timer.sv | 29 ++
 rtl/elevator_scheduler.sv | 148 ++++++++++++++
 tb/tb_elevator_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam int unsigned NUM_FLOORS_DEF    = 8;
  localparam int unsigned TRAVEL_CYCLES_DEF = 4;
  localparam int unsigned DOOR_CYCLES_DEF   = 8;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero and freezes while disabled.
module cycle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - WIDTH'(1);
      end
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car elevator controller: latches calls, serves them with a LOOK sweep,
// and times floor travel and door dwell.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = NUM_FLOORS_DEF,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int unsigned DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  estop,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  arrived
);

  localparam int unsigned TT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TT_W-1:0] TRAVEL_LOAD = TT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DT_W-1:0] DOOR_LOAD   = DT_W'(DOOR_CYCLES - 1);

  state_t                  state, state_d;
  logic [FLOOR_W-1:0]      floor_d, step_floor, sel_floor;
  logic                    dir_d;
  logic [NUM_FLOORS-1:0]   pending_d, sel_onehot, cur_onehot;
  logic                    above_any, below_any, sel_hit, call_here;
  logic                    step, travel_load, door_load;
  logic                    travel_zero_c, door_zero_c;

  // Reference floor is the current one in IDLE and the floor being stepped to in MOVE.
  always_comb begin
    step_floor = dir_up ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
    sel_floor  = (state == MOVE) ? step_floor : cur_floor;
    above_any  = 1'b0;
    below_any  = 1'b0;
    sel_onehot = '0;
    cur_onehot = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == sel_floor) sel_onehot[i] = 1'b1;
      if (FLOOR_W'(i) == cur_floor) cur_onehot[i] = 1'b1;
      if (pending[i] && (FLOOR_W'(i) > sel_floor)) above_any = 1'b1;
      if (pending[i] && (FLOOR_W'(i) < sel_floor)) below_any = 1'b1;
    end
    sel_hit   = |(pending & sel_onehot);
    call_here = |(call_req & cur_onehot);
  end

  // Next state, floor, direction and call latch; estop holds everything but the latch.
  always_comb begin
    state_d     = state;
    floor_d     = cur_floor;
    dir_d       = dir_up;
    step        = 1'b0;
    travel_load = 1'b0;
    door_load   = 1'b0;
    pending_d   = pending | (call_req & ~(cur_onehot & {NUM_FLOORS{state == DOOR}}));
    if (!estop) begin
      case (state)
        IDLE: begin
          if (sel_hit) begin
            state_d = DOOR;
          end else if (above_any && below_any) begin
            state_d = MOVE;
          end else if (above_any) begin
            state_d = MOVE;
            dir_d   = 1'b1;
          end else if (below_any) begin
            state_d = MOVE;
            dir_d   = 1'b0;
          end
        end
        MOVE: begin
          if (travel_zero_c) begin
            step        = 1'b1;
            floor_d     = step_floor;
            travel_load = 1'b1;
            if (sel_hit) begin
              state_d = DOOR;
            end else if (dir_up ? above_any : below_any) begin
              state_d = MOVE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DOOR: begin
          if (call_here) begin
            door_load = 1'b1;
          end else if (door_zero_c) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if ((state == IDLE) && (state_d == MOVE)) travel_load = 1'b1;
      // Door entry serves the reference floor; its clear beats a same-cycle call.
      if ((state != DOOR) && (state_d == DOOR)) begin
        door_load = 1'b1;
        pending_d = pending_d & ~sel_onehot;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      pending   <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrived   <= 1'b0;
    end else begin
      state     <= state_d;
      cur_floor <= floor_d;
      dir_up    <= dir_d;
      pending   <= pending_d;
      moving    <= (state_d == MOVE);
      door_open <= (state_d == DOOR);
      arrived   <= step;
    end
  end

  cycle_timer #(.WIDTH(TT_W)) u_travel_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (travel_load),
    .load_val (TRAVEL_LOAD),
    .en       (~estop),
    .zero_c   (travel_zero_c)
  );

  cycle_timer #(.WIDTH(DT_W)) u_door_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (door_load),
    .load_val (DOOR_LOAD),
    .en       (~estop),
    .zero_c   (door_zero_c)
  );

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed self-checking bench for elevator_scheduler at default parameters.
module tb_elevator_scheduler;

  logic       clk;
  logic       reset_n;
  logic [7:0] call_req;
  logic       estop;
  logic [2:0] cur_floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic [7:0] pending;
  logic       arrived;

  int checks = 0;
  int errors = 0;

  elevator_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .call_req  (call_req),
    .estop     (estop),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending),
    .arrived   (arrived)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive call_req[f] for exactly one sampling edge.
  task automatic call(input int f);
    call_req    = '0;
    call_req[f] = 1'b1;
    tick();
    call_req = '0;
  endtask

  // Advance until an arrival pulse, bounded; returns cycles taken.
  task automatic run_to_arrival(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!arrived && n < 40);
  endtask

  // Count cycles the door stays open starting from the current cycle.
  task automatic count_door(output int n);
    n = 0;
    while (door_open && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    call_req = '0;
    estop    = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (cur_floor !== 3'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", cur_floor); end
    checks++;
    if ({dir_up, moving, door_open, arrived} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b expected 1000", {dir_up, moving, door_open, arrived});
    end
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h expected 00", pending); end
  endtask

  task automatic test_single_call();
    int n;
    call(3);
    checks++;
    if (pending !== 8'h08) begin errors++; $display("FAIL single_latch: got %h expected 08", pending); end
    checks++;
    if (moving !== 1'b0) begin errors++; $display("FAIL single_not_yet_moving: got %b expected 0", moving); end
    tick();
    checks++;
    if (moving !== 1'b1) begin errors++; $display("FAIL single_move_start: got %b expected 1", moving); end
    for (int f = 1; f <= 3; f++) begin
      run_to_arrival(n);
      checks++;
      if (n !== 4) begin errors++; $display("FAIL single_step_spacing floor %0d: got %0d expected 4", f, n); end
      checks++;
      if (cur_floor !== 3'(f)) begin errors++; $display("FAIL single_floor: got %0d expected %0d", cur_floor, f); end
    end
    checks++;
    if ({door_open, moving} !== 2'b10) begin
      errors++; $display("FAIL single_door_entry: got %b expected 10", {door_open, moving});
    end
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL single_pending_clear: got %h expected 00", pending); end
    count_door(n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL single_door_len: got %0d expected 8", n); end
    tick();
    checks++;
    if ({moving, door_open, arrived} !== 3'b000) begin
      errors++; $display("FAIL single_idle: got %b expected 000", {moving, door_open, arrived});
    end
  endtask

  task automatic test_look();
    int n;
    call_req = 8'h22;
    tick();
    call_req = '0;
    checks++;
    if (pending !== 8'h22) begin errors++; $display("FAIL look_latch: got %h expected 22", pending); end
    tick();
    checks++;
    if ({moving, dir_up} !== 2'b11) begin errors++; $display("FAIL look_start_up: got %b expected 11", {moving, dir_up}); end
    run_to_arrival(n);
    checks++;
    if ({cur_floor, door_open, moving} !== {3'd4, 1'b0, 1'b1}) begin
      errors++; $display("FAIL look_pass4: got floor %0d door %b moving %b expected 4 0 1", cur_floor, door_open, moving);
    end
    run_to_arrival(n);
    checks++;
    if ({cur_floor, door_open} !== {3'd5, 1'b1}) begin
      errors++; $display("FAIL look_serve5: got floor %0d door %b expected 5 1", cur_floor, door_open);
    end
    checks++;
    if (pending !== 8'h02) begin errors++; $display("FAIL look_pending_after5: got %h expected 02", pending); end
    count_door(n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL look_door5_len: got %0d expected 8", n); end
    tick();
    checks++;
    if ({moving, dir_up} !== 2'b10) begin errors++; $display("FAIL look_reverse: got %b expected 10", {moving, dir_up}); end
    for (int f = 4; f >= 1; f--) begin
      run_to_arrival(n);
      checks++;
      if (n !== 4 || cur_floor !== 3'(f)) begin
        errors++; $display("FAIL look_down_step: got floor %0d after %0d cycles expected %0d after 4", cur_floor, n, f);
      end
    end
    checks++;
    if ({door_open, dir_up, pending} !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL look_serve1: got door %b dir %b pending %h expected 1 0 00", door_open, dir_up, pending);
    end
    count_door(n);
  endtask

  task automatic test_reset_mid_move();
    int n;
    call(5);
    tick();
    run_to_arrival(n);
    checks++;
    if ({cur_floor, moving} !== {3'd2, 1'b1}) begin
      errors++; $display("FAIL rst_precondition: got floor %0d moving %b expected 2 1", cur_floor, moving);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cur_floor, moving, door_open, pending} !== {3'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rst_async: got floor %0d moving %b door %b pending %h expected 0 0 0 00",
                         cur_floor, moving, door_open, pending);
    end
    checks++;
    if ({dir_up, arrived} !== 2'b10) begin errors++; $display("FAIL rst_async_flags: got %b expected 10", {dir_up, arrived}); end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({cur_floor, moving, door_open} !== {3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_idle_after: got floor %0d moving %b door %b expected 0 0 0", cur_floor, moving, door_open);
    end
  endtask

  task automatic test_same_floor();
    int n;
    call(0);
    checks++;
    if ({pending, door_open} !== {8'h01, 1'b0}) begin
      errors++; $display("FAIL same_latch: got pending %h door %b expected 01 0", pending, door_open);
    end
    tick();
    checks++;
    if ({door_open, moving, pending} !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL same_door_open: got door %b moving %b pending %h expected 1 0 00", door_open, moving, pending);
    end
    repeat (5) tick();
    call(0);
    checks++;
    if ({door_open, pending} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL same_reopen_masked: got door %b pending %h expected 1 00", door_open, pending);
    end
    count_door(n);
    checks++;
    if (6 + n !== 14) begin errors++; $display("FAIL same_door_total: got %0d expected 14", 6 + n); end
    checks++;
    if ({cur_floor, moving} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL same_no_move: got floor %0d moving %b expected 0 0", cur_floor, moving);
    end
  endtask

  task automatic test_estop();
    int n;
    call(2);
    tick();
    tick();
    estop = 1'b1;
    for (int k = 0; k < 10; k++) begin
      call_req = (k == 3) ? 8'h40 : 8'h00;
      tick();
      checks++;
      if ({cur_floor, moving, door_open, arrived} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL estop_frozen cycle %0d: got floor %0d moving %b door %b arrived %b expected 0 1 0 0",
                           k, cur_floor, moving, door_open, arrived);
      end
    end
    call_req = '0;
    checks++;
    if (pending !== 8'h44) begin errors++; $display("FAIL estop_latch: got %h expected 44", pending); end
    estop = 1'b0;
    run_to_arrival(n);
    checks++;
    if (n !== 3 || cur_floor !== 3'd1) begin
      errors++; $display("FAIL estop_resume: got floor %0d after %0d cycles expected 1 after 3", cur_floor, n);
    end
    run_to_arrival(n);
    checks++;
    if ({n == 4, cur_floor, door_open, pending} !== {1'b1, 3'd2, 1'b1, 8'h40}) begin
      errors++; $display("FAIL estop_serve2: got n %0d floor %0d door %b pending %h expected 4 2 1 40",
                         n, cur_floor, door_open, pending);
    end
  endtask

  task automatic test_top_bound();
    int n;
    apply_reset();
    call(7);
    tick();
    for (int f = 1; f <= 7; f++) begin
      run_to_arrival(n);
      checks++;
      if (n !== 4 || cur_floor !== 3'(f)) begin
        errors++; $display("FAIL top_step: got floor %0d after %0d cycles expected %0d after 4", cur_floor, n, f);
      end
    end
    checks++;
    if (door_open !== 1'b1) begin errors++; $display("FAIL top_door: got %b expected 1", door_open); end
    count_door(n);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({cur_floor, moving, dir_up} !== {3'd7, 1'b0, 1'b1}) begin
        errors++; $display("FAIL top_hold: got floor %0d moving %b dir %b expected 7 0 1", cur_floor, moving, dir_up);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    call_req = '0;
    estop    = 1'b0;
    test_reset();
    test_single_call();
    test_look();
    test_reset_mid_move();
    test_same_floor();
    test_estop();
    test_top_bound();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
